// File: rtl/ci_stim_pkg.sv
// Shared types and defaults for the stimulation pulse sequencer.
// Holds the FSM state encoding, bridge/LED payloads and their decoders.
package ci_stim_pkg;

  localparam int unsigned PHASE_UNIT_DEF = 100;
  localparam int unsigned IDLE_UNIT_DEF  = 1000;
  localparam int unsigned DEAD_CYC_DEF   = 4;
  localparam int unsigned IPG_CYC_DEF    = 10;
  localparam int unsigned CNT_W_DEF      = 16;
  localparam int unsigned PCNT_W         = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LATCH,
    ST_DT0,
    ST_CATH,
    ST_IPG,
    ST_ANOD,
    ST_DT1,
    ST_REST
  } state_t;

  typedef struct packed {
    logic ano_top;
    logic cat_bot;
    logic cat_top;
    logic ano_bot;
  } bridge_t;

  typedef struct packed {
    logic r;
    logic g;
  } led_rg_t;

  localparam led_rg_t LED_STOPPED = '{r: 1'b1, g: 1'b0};
  localparam led_rg_t LED_RUNNING = '{r: 1'b0, g: 1'b1};

  // Only the two phase states ever close a switch pair, so the pairs are exclusive by construction.
  function automatic bridge_t bridge_decode(input state_t s);
    bridge_t b;
    b = '0;
    case (s)
      ST_CATH: begin
        b.cat_top = 1'b1;
        b.ano_bot = 1'b1;
      end
      ST_ANOD: begin
        b.ano_top = 1'b1;
        b.cat_bot = 1'b1;
      end
      default: ;
    endcase
    return b;
  endfunction

  function automatic led_rg_t led_decode(input state_t s);
    return (s == ST_IDLE) ? LED_STOPPED : LED_RUNNING;
  endfunction

endpackage

// File: rtl/ci_btn_sync.sv
// Two-flop synchronizer for an asynchronous button, with optional rising-edge output.
// RISE_EDGE=1 gives a one-clock pulse on the synchronized rising edge; 0 gives the level.
module ci_btn_sync #(
  parameter bit RISE_EDGE = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_btn_c
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= i_btn;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_btn_c = RISE_EDGE ? (r_sync & ~r_prev) : r_sync;

endmodule

// File: rtl/ci_stim_pulse_sequencer.sv
// Biphasic, charge-balanced pulse-train sequencer for the stimulation H-bridge.
// Outputs are registered from the next state so they line up with the state register.
module ci_stim_pulse_sequencer
  import ci_stim_pkg::*;
#(
  parameter int unsigned PHASE_UNIT = PHASE_UNIT_DEF,
  parameter int unsigned IDLE_UNIT  = IDLE_UNIT_DEF,
  parameter int unsigned DEAD_CYC   = DEAD_CYC_DEF,
  parameter int unsigned IPG_CYC    = IPG_CYC_DEF,
  parameter int unsigned CNT_W      = CNT_W_DEF
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start_btn,
  input  logic        i_stop_btn,
  input  logic [2:0]  i_duty,
  input  logic [2:0]  i_idle,
  output logic        o_ano_top,
  output logic        o_cat_bot,
  output logic        o_cat_top,
  output logic        o_ano_bot,
  output logic        o_curr_ena,
  output logic        o_led_r,
  output logic        o_led_g,
  output logic        o_led_b,
  output logic [15:0] o_pulse_cnt
);

  // Counters load duration-1 on state entry and leave the state when they reach zero.
  localparam logic [CNT_W-1:0] DEAD_LD = CNT_W'(DEAD_CYC - 32'd1);
  localparam logic [CNT_W-1:0] IPG_LD  = CNT_W'(IPG_CYC - 32'd1);

  logic                w_start_evt;
  logic                w_stop_lvl;
  logic                w_stop;
  logic                w_last;
  logic                w_done_c;
  logic [CNT_W-1:0]    w_phase_ld;
  logic [CNT_W-1:0]    w_rest_ld;
  logic [CNT_W-1:0]    w_cnt_load;
  state_t              w_state_nxt;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [2:0]          r_duty;
  logic [2:0]          r_idle;
  logic                r_stop_pend;
  bridge_t             r_bridge;
  logic                r_curr_ena;
  led_rg_t             r_led;
  logic                r_led_b;
  logic [PCNT_W-1:0]   r_pulse_cnt;

  ci_btn_sync #(.RISE_EDGE(1'b1)) u_start_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_btn   (i_start_btn),
    .o_btn_c (w_start_evt)
  );

  ci_btn_sync #(.RISE_EDGE(1'b0)) u_stop_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_btn   (i_stop_btn),
    .o_btn_c (w_stop_lvl)
  );

  assign w_stop     = w_stop_lvl | r_stop_pend;
  assign w_last     = (r_cnt == '0);
  assign w_done_c   = (r_state == ST_DT1) && w_last;
  assign w_phase_ld = CNT_W'((32'(r_duty) + 32'd1) * PHASE_UNIT - 32'd1);
  assign w_rest_ld  = CNT_W'((32'(r_idle) + 32'd1) * IDLE_UNIT - 32'd1);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Once current has flowed the pulse always runs through ANOD and DT1 before a stop is honoured.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_load  = '0;
    case (r_state)
      ST_IDLE:  if (w_start_evt && !w_stop_lvl) w_state_nxt = ST_LATCH;
      ST_LATCH: w_state_nxt = w_stop ? ST_IDLE : ST_DT0;
      ST_DT0: begin
        if (w_stop)      w_state_nxt = ST_IDLE;
        else if (w_last) w_state_nxt = ST_CATH;
      end
      ST_CATH:  if (w_last) w_state_nxt = ST_IPG;
      ST_IPG:   if (w_last) w_state_nxt = ST_ANOD;
      ST_ANOD:  if (w_last) w_state_nxt = ST_DT1;
      ST_DT1:   if (w_last) w_state_nxt = w_stop ? ST_IDLE : ST_REST;
      ST_REST: begin
        if (w_stop)      w_state_nxt = ST_IDLE;
        else if (w_last) w_state_nxt = ST_LATCH;
      end
      default:  w_state_nxt = ST_IDLE;
    endcase
    case (w_state_nxt)
      ST_DT0, ST_DT1:   w_cnt_load = DEAD_LD;
      ST_CATH, ST_ANOD: w_cnt_load = w_phase_ld;
      ST_IPG:           w_cnt_load = IPG_LD;
      ST_REST:          w_cnt_load = w_rest_ld;
      default:          w_cnt_load = '0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (w_state_nxt != r_state) begin
      r_cnt <= w_cnt_load;
    end else if (!w_last) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  // Codes are captured only in LATCH so a pulse never changes shape mid-flight.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_duty <= '0;
      r_idle <= '0;
    end else if (r_state == ST_LATCH) begin
      r_duty <= i_duty;
      r_idle <= i_idle;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stop_pend <= 1'b0;
    end else if (w_state_nxt == ST_IDLE) begin
      r_stop_pend <= 1'b0;
    end else if (w_stop_lvl) begin
      r_stop_pend <= 1'b1;
    end
  end

  // Current enable is derived from the switch decode so it can never be on with the bridge open.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_bridge    <= '0;
      r_curr_ena  <= 1'b0;
      r_led       <= LED_STOPPED;
      r_led_b     <= 1'b0;
      r_pulse_cnt <= '0;
    end else begin
      r_bridge   <= bridge_decode(w_state_nxt);
      r_curr_ena <= |bridge_decode(w_state_nxt);
      r_led      <= led_decode(w_state_nxt);
      if (w_done_c) begin
        r_led_b     <= ~r_led_b;
        r_pulse_cnt <= r_pulse_cnt + PCNT_W'(1);
      end
    end
  end

  assign o_ano_top   = r_bridge.ano_top;
  assign o_cat_bot   = r_bridge.cat_bot;
  assign o_cat_top   = r_bridge.cat_top;
  assign o_ano_bot   = r_bridge.ano_bot;
  assign o_curr_ena  = r_curr_ena;
  assign o_led_r     = r_led.r;
  assign o_led_g     = r_led.g;
  assign o_led_b     = r_led_b;
  assign o_pulse_cnt = r_pulse_cnt;

endmodule

// File: tb/tb_ci_stim_pulse_sequencer.sv
// Directed bench for ci_stim_pulse_sequencer: phase timing, code re-sampling, stop paths, reset.
// A per-cycle monitor guards the bridge-overlap and current-enable invariants.
`timescale 1ns/1ps
module tb_ci_stim_pulse_sequencer;

  localparam int CAT = 0;
  localparam int ANO = 1;
  localparam logic [23:0] RST_OUTS = 24'h040000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_btn = 1'b0;
  logic        stop_btn = 1'b0;
  logic [2:0]  duty = 3'd0;
  logic [2:0]  idle = 3'd0;
  logic        ano_top, cat_bot, cat_top, ano_bot, curr_ena;
  logic        led_r, led_g, led_b;
  logic [15:0] pulse_cnt;
  logic [23:0] outs;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  ci_stim_pulse_sequencer dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_start_btn (start_btn),
    .i_stop_btn  (stop_btn),
    .i_duty      (duty),
    .i_idle      (idle),
    .o_ano_top   (ano_top),
    .o_cat_bot   (cat_bot),
    .o_cat_top   (cat_top),
    .o_ano_bot   (ano_bot),
    .o_curr_ena  (curr_ena),
    .o_led_r     (led_r),
    .o_led_g     (led_g),
    .o_led_b     (led_b),
    .o_pulse_cnt (pulse_cnt)
  );

  assign outs = {ano_top, cat_bot, cat_top, ano_bot, curr_ena, led_r, led_g, led_b, pulse_cnt};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic pick(input int s);
    case (s)
      CAT:     return cat_top;
      ANO:     return ano_top;
      default: return led_g;
    endcase
  endfunction

  // Bounded wait; a timeout leaves n at max, which the caller's check then rejects.
  task automatic wait_val(input int s, input logic v, input int max, output int n);
    n = 0;
    while (pick(s) !== v && n < max) begin
      @(negedge clk);
      n++;
    end
  endtask

  always @(negedge clk) begin
    checks++;
    assert (!((cat_top | ano_bot) & (ano_top | cat_bot)) &&
            !(curr_ena && !(cat_top | ano_bot | ano_top | cat_bot))) else begin
      errors++;
      $error("FAIL safety: observed sw=%b%b%b%b ena=%b expected no overlap and no idle current",
             cat_top, ano_bot, ano_top, cat_bot, curr_ena);
    end
  end

  initial begin
    int n;
    int tot;
    int bad;

    repeat (3) @(negedge clk);
    check("reset_outs", 32'(outs), 32'(RST_OUTS));
    rst_n = 1'b1;
    bad = 0;
    repeat (10000) begin
      @(negedge clk);
      if (outs !== RST_OUTS) bad++;
    end
    check("idle_10k_stable", 32'(bad), 32'd0);

    // duty=0, idle=0: W=100, R=1000, period 1219
    start_btn = 1'b1;
    repeat (2) @(negedge clk);
    check("start_lat2_idle", 32'(led_g), 32'd0);
    @(negedge clk);
    check("start_lat3_leds", 32'({led_r, led_g}), 32'd1);
    start_btn = 1'b0;
    wait_val(CAT, 1'b1, 50, n);
    check("latch_dt0_len", 32'(n), 32'd5);
    check("cath_drive", 32'(outs[23:19]), 32'(5'b00111));
    wait_val(CAT, 1'b0, 2000, n);
    check("cath_width", 32'(n), 32'd100);
    tot = n;
    check("ipg_all_off", 32'(outs[23:19]), 32'd0);
    wait_val(ANO, 1'b1, 50, n);
    check("ipg_width", 32'(n), 32'd10);
    tot += n;
    check("anod_drive", 32'(outs[23:19]), 32'(5'b11001));
    wait_val(ANO, 1'b0, 2000, n);
    check("anod_width", 32'(n), 32'd100);
    tot += n;
    check("cnt_in_dt1", 32'(pulse_cnt), 32'd0);
    repeat (4) @(negedge clk);
    tot += 4;
    check("cnt_pulse1", 32'(pulse_cnt), 32'd1);
    check("led_b_pulse1", 32'(led_b), 32'd1);
    wait_val(CAT, 1'b1, 5000, n);
    tot += n;
    check("period_0_0", 32'(tot), 32'd1219);

    for (int k = 2; k <= 3; k++) begin
      check("cnt_at_rise", 32'(pulse_cnt), 32'(k - 1));
      wait_val(CAT, 1'b0, 2000, n);
      tot = n;
      wait_val(CAT, 1'b1, 5000, n);
      tot += n;
      check("period_repeat", 32'(tot), 32'd1219);
    end

    // New codes applied mid-CATH of pulse 4 only take effect from pulse 5
    check("cnt_rise4", 32'(pulse_cnt), 32'd3);
    duty = 3'd7;
    idle = 3'd3;
    wait_val(CAT, 1'b0, 2000, n);
    check("cath_width_old_code", 32'(n), 32'd100);
    tot = n;
    wait_val(CAT, 1'b1, 10000, n);
    tot += n;
    check("period_old_code", 32'(tot), 32'd1219);

    // Pulse 5: W=800, R=4000, period 5619; duty change mid-CATH ignored
    check("cnt_rise5", 32'(pulse_cnt), 32'd4);
    repeat (50) @(negedge clk);
    duty = 3'd0;
    wait_val(CAT, 1'b0, 2000, n);
    check("cath_width_duty7", 32'(50 + n), 32'd800);
    tot = 50 + n;
    wait_val(ANO, 1'b1, 50, n);
    tot += n;
    wait_val(ANO, 1'b0, 2000, n);
    check("anod_width_duty7", 32'(n), 32'd800);
    tot += n;
    wait_val(CAT, 1'b1, 10000, n);
    tot += n;
    check("period_7_3", 32'(tot), 32'd5619);

    // Pulse 6 (duty=0): stop 50 clocks into CATH, pulse completes then IDLE
    check("cnt_rise6", 32'(pulse_cnt), 32'd5);
    repeat (50) @(negedge clk);
    stop_btn = 1'b1;
    wait_val(CAT, 1'b0, 2000, n);
    check("stop_cath_full", 32'(50 + n), 32'd100);
    wait_val(ANO, 1'b1, 50, n);
    check("stop_ipg_full", 32'(n), 32'd10);
    wait_val(ANO, 1'b0, 2000, n);
    check("stop_anod_full", 32'(n), 32'd100);
    repeat (3) @(negedge clk);
    check("stop_dt1_running", 32'(led_g), 32'd1);
    @(negedge clk);
    check("stop_idle_leds", 32'({led_r, led_g}), 32'd2);
    check("stop_final_cnt", 32'(pulse_cnt), 32'd6);
    check("stop_led_b", 32'(led_b), 32'd0);
    bad = 0;
    repeat (2000) begin
      @(negedge clk);
      if (cat_top | ano_top | led_g) bad++;
    end
    check("stopped_stays_idle", 32'(bad), 32'd0);
    stop_btn = 1'b0;
    repeat (5) @(negedge clk);

    // Start and stop together in IDLE: stop wins, later stop release does not start
    start_btn = 1'b1;
    stop_btn  = 1'b1;
    bad = 0;
    repeat (30) begin
      @(negedge clk);
      if (outs[23:16] !== 8'b00000100) bad++;
    end
    stop_btn = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (outs[23:16] !== 8'b00000100) bad++;
    end
    check("simul_start_stop", 32'(bad), 32'd0);
    start_btn = 1'b0;
    repeat (5) @(negedge clk);

    // Stop during REST: IDLE three clocks after the press
    start_btn = 1'b1;
    repeat (3) @(negedge clk);
    start_btn = 1'b0;
    wait_val(CAT, 1'b1, 50, n);
    check("restart_latch_dt0", 32'(n), 32'd5);
    wait_val(ANO, 1'b1, 200, n);
    wait_val(ANO, 1'b0, 200, n);
    check("restart_anod_width", 32'(n), 32'd100);
    repeat (4) @(negedge clk);
    check("cnt_pulse7", 32'(pulse_cnt), 32'd7);
    repeat (10) @(negedge clk);
    stop_btn = 1'b1;
    repeat (2) @(negedge clk);
    check("rest_stop_lat2", 32'(led_g), 32'd1);
    @(negedge clk);
    check("rest_stop_idle", 32'({led_r, led_g}), 32'd2);
    check("rest_stop_cnt", 32'(pulse_cnt), 32'd7);
    stop_btn = 1'b0;
    repeat (5) @(negedge clk);

    // Asynchronous reset mid-CATH
    start_btn = 1'b1;
    repeat (3) @(negedge clk);
    start_btn = 1'b0;
    wait_val(CAT, 1'b1, 50, n);
    repeat (20) @(negedge clk);
    check("pre_reset_cath", 32'(cat_top), 32'd1);
    #2 rst_n = 1'b0;
    #1 check("async_reset_outs", 32'(outs), 32'(RST_OUTS));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("post_reset_idle", 32'(outs), 32'(RST_OUTS));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
